// File: rtl/clk_en_scheduler.sv
// Per-channel clock-enable strobe generator with IDLE/SYNC/RUN phase alignment.
// Latency: strobe registered; first strobe D+2 edges after run is sampled high.
// Backpressure: cfg_ready low in SYNC, and in RUN while a ratio change is pending.
module clk_en_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] en_pulse,
    output logic [3:0]        pulse_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    state_t state_q;
    state_t state_d;

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;

    logic              pend_vld;
    logic [2:0]        pend_ch;
    logic [DIV_W-1:0]  pend_div;
    logic              pend_en;

    logic              cfg_fire;
    logic              cfg_hit;
    logic              run_exit;
    logic              direct_wr;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_SYNC;
            ST_SYNC: state_d = run ? ST_RUN : ST_IDLE;
            ST_RUN:  if (!run) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        cfg_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pend_vld);
    end

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_hit   = cfg_fire && ({1'b0, cfg_ch} < NUM_CH_L);
    assign run_exit  = (state_q == ST_RUN) && !run;
    // Writes landing on the RUN->IDLE edge bypass the slot so nothing lingers into IDLE.
    assign direct_wr = cfg_hit && ((state_q == ST_IDLE) || run_exit);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            strobe[i] = (state_q == ST_RUN) && run && en_q[i] && (cnt_q[i] == '0);
            apply[i]  = pend_vld && (pend_ch == 3'(i)) &&
                        (run_exit || !en_q[i] || (cnt_q[i] == '0));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_div  <= '0;
            pend_en   <= 1'b0;
            en_q      <= '0;
            en_pulse  <= '0;
            pulse_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            if (|apply) begin
                pend_vld <= 1'b0;
            end
            if (cfg_hit && (state_q == ST_RUN) && run) begin
                pend_vld <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
                pend_en  <= cfg_en;
            end

            if (strobe[0]) begin
                pulse_cnt <= pulse_cnt + 4'd1;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                en_pulse[i] <= strobe[i];
                if (state_q == ST_SYNC) begin
                    cnt_q[i] <= div_q[i];
                end else if ((state_q == ST_RUN) && run && en_q[i]) begin
                    // Terminal-count reload picks up a pending ratio so no period is cut short.
                    if (cnt_q[i] == '0) begin
                        cnt_q[i] <= apply[i] ? pend_div : div_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] - DIV_W'(1);
                    end
                end

                if (apply[i]) begin
                    div_q[i] <= pend_div;
                    en_q[i]  <= pend_en;
                end
                if (direct_wr && (cfg_ch == 3'(i))) begin
                    div_q[i] <= cfg_div;
                    en_q[i]  <= cfg_en;
                end
            end
        end
    end

endmodule
